// File: rtl/mtx_hop_scheduler.sv
// Frequency-hop sequencer for the multi-tone generator: hop table, srst/valid control.
// Optional MTX_HOP_SCHED_LFSR_EN selects pseudo-random hop order instead of sequential.
module mtx_hop_scheduler #(
  parameter int PHASE_WIDTH   = 24,
  parameter int NHOP_MAX_LOG2 = 4,
  parameter int GAP_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [NHOP_MAX_LOG2-1:0] cfg_addr,
  input  logic [PHASE_WIDTH-1:0]   cfg_data,
  input  logic [NHOP_MAX_LOG2:0]   nhops,
  input  logic [GAP_WIDTH-1:0]     gap_cycles,
  input  logic                     continuous,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     gen_hop_done,
  input  logic                     gen_phase_tready,
  output logic                     gen_srst,
  output logic                     gen_phase_tvalid,
  output logic                     gen_phase_tlast,
  output logic [PHASE_WIDTH-1:0]   hop_phase_inc,
  output logic [NHOP_MAX_LOG2-1:0] hop_idx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int DEPTH = 1 << NHOP_MAX_LOG2;
  localparam logic [NHOP_MAX_LOG2:0] DEPTH_N = {1'b1, {NHOP_MAX_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  state_t state, state_nx;

  logic [PHASE_WIDTH-1:0]   hop_tab [DEPTH];
  logic [NHOP_MAX_LOG2:0]   nhops_q, cnt;
  logic [GAP_WIDTH-1:0]     gap_q, gap_cnt;
  logic [NHOP_MAX_LOG2-1:0] idx_nx;
  logic                     last, start_ok, hop_adv, hop_end;
  logic                     unused_ready;

  // The generator applies its own backpressure; tvalid never waits on tready.
  assign unused_ready = gen_phase_tready;

  assign last     = (cnt == nhops_q - 1'b1);
  assign start_ok = start && (nhops != '0) && (nhops <= DEPTH_N);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (cfg_we) hop_tab[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    gen_srst         = 1'b1;
    gen_phase_tvalid = 1'b0;
    gen_phase_tlast  = 1'b0;
    hop_adv          = 1'b0;
    hop_end          = 1'b0;
    unique case (state)
      IDLE: if (start_ok) state_nx = LOAD;
      LOAD: state_nx = RUN;
      RUN: begin
        gen_srst         = 1'b0;
        gen_phase_tvalid = 1'b1;
        gen_phase_tlast  = last;
        if (gen_hop_done) begin
          if (last) begin
            hop_end  = 1'b1;
            state_nx = continuous ? LOAD : IDLE;
          end else begin
            hop_adv  = 1'b1;
            state_nx = (gap_q != '0) ? GAP : LOAD;
          end
        end
      end
      GAP: if (gap_cnt == gap_q - 1'b1) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
    // Abort beats a same-cycle hop completion.
    if (stop && state != IDLE) begin
      state_nx = IDLE;
      hop_adv  = 1'b0;
      hop_end  = 1'b0;
    end
  end

`ifdef MTX_HOP_SCHED_LFSR_EN
  localparam logic [15:0] SEED = 16'hACE1;
  logic [15:0]              lfsr;
  logic [NHOP_MAX_LOG2-1:0] rnd;
  logic [NHOP_MAX_LOG2-1:0] nh_lo;

  assign nh_lo = nhops_q[NHOP_MAX_LOG2-1:0];

  always_comb begin
    rnd = lfsr[NHOP_MAX_LOG2-1:0];
    if ({1'b0, rnd} >= nhops_q) rnd = rnd - nh_lo;
    if ({1'b0, rnd} >= nhops_q) rnd = rnd - nh_lo;
  end

  assign idx_nx = rnd;

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= SEED;
    else if (state == IDLE && start_ok)
      lfsr <= SEED;
    else if (hop_adv || hop_end)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
`else
  assign idx_nx = hop_idx + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      nhops_q       <= '0;
      gap_q         <= '0;
      cnt           <= '0;
      gap_cnt       <= '0;
      hop_idx       <= '0;
      hop_phase_inc <= '0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= hop_end;
      gap_cnt    <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && start_ok) begin
        nhops_q <= nhops;
        gap_q   <= gap_cycles;
        hop_idx <= '0;
        cnt     <= '0;
      end
      if (state == LOAD) hop_phase_inc <= hop_tab[hop_idx];
      if (hop_adv) begin
        hop_idx <= idx_nx;
        cnt     <= cnt + 1'b1;
      end
      if (hop_end) begin
        hop_idx <= '0;
        cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mtx_hop_scheduler.sv
// Directed vector bench for mtx_hop_scheduler.
// Covers sequencing, gaps, continuous mode, stop/reset aborts and the LFSR build.
module tb_mtx_hop_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic [4:0]  nhops;
  logic [15:0] gap_cycles;
  logic        continuous, start, stop, gen_hop_done, gen_phase_tready;
  logic        gen_srst, gen_phase_tvalid, gen_phase_tlast;
  logic [23:0] hop_phase_inc;
  logic [3:0]  hop_idx;
  logic        busy, frame_done;

  int n_chk = 0;
  int n_fail = 0;

  mtx_hop_scheduler dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .nhops(nhops), .gap_cycles(gap_cycles), .continuous(continuous),
    .start(start), .stop(stop), .gen_hop_done(gen_hop_done),
    .gen_phase_tready(gen_phase_tready),
    .gen_srst(gen_srst), .gen_phase_tvalid(gen_phase_tvalid),
    .gen_phase_tlast(gen_phase_tlast), .hop_phase_inc(hop_phase_inc),
    .hop_idx(hop_idx), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st, sp, hd, ct;
    logic [4:0]  nh;
    logic [15:0] gp;
    logic        bz, sr, tv, tl, fd;
    logic [3:0]  ix;
    logic [23:0] ph;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int st, sp, hd, ct, nh, gp,
                     input int bz, sr, tv, tl, fd, ix, ph);
    vec_t v;
    v.st = st[0]; v.sp = sp[0]; v.hd = hd[0]; v.ct = ct[0];
    v.nh = nh[4:0]; v.gp = gp[15:0];
    v.bz = bz[0]; v.sr = sr[0]; v.tv = tv[0]; v.tl = tl[0]; v.fd = fd[0];
    v.ix = ix[3:0]; v.ph = ph[23:0];
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [23:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Edges until tvalid is seen; also counts srst-held idle samples on the way.
  task automatic wait_tv(output int n, output int idle);
    n = 0; idle = 0;
    do begin
      tick();
      start = 1'b0; gen_hop_done = 1'b0;
      n++;
      if (!gen_phase_tvalid && gen_srst) idle++;
    end while (!gen_phase_tvalid && n < 40);
  endtask

  task automatic chk_all(input string p, input vec_t v);
    chk({p, ".busy"}, {31'd0, busy}, {31'd0, v.bz});
    chk({p, ".srst"}, {31'd0, gen_srst}, {31'd0, v.sr});
    chk({p, ".tvalid"}, {31'd0, gen_phase_tvalid}, {31'd0, v.tv});
    chk({p, ".tlast"}, {31'd0, gen_phase_tlast}, {31'd0, v.tl});
    chk({p, ".frame_done"}, {31'd0, frame_done}, {31'd0, v.fd});
    chk({p, ".idx"}, {28'd0, hop_idx}, {28'd0, v.ix});
    chk({p, ".phase"}, {8'd0, hop_phase_inc}, {8'd0, v.ph});
  endtask

`ifdef MTX_HOP_SCHED_LFSR_EN
  logic [3:0] seq_a [12];

  task automatic lfsr_run(input bit cmp);
    int n, idle;
    nhops = 5'd8; gap_cycles = '0; continuous = 1'b1; start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_tv(n, idle);
      chk($sformatf("lfsr.lat%0d", i), n, (i == 0) ? 2 : 2);
      chk($sformatf("lfsr.range%0d", i), {31'd0, hop_idx < 4'd8}, 32'd1);
      if (i == 0) chk("lfsr.first", {28'd0, hop_idx}, 32'd0);
      if (cmp) chk($sformatf("lfsr.rep%0d", i), {28'd0, hop_idx}, {28'd0, seq_a[i]});
      else seq_a[i] = hop_idx;
      gen_hop_done = 1'b1;
    end
    tick();
    gen_hop_done = 1'b0;
  endtask
`endif

  initial begin
    int n, idle;
    vec_t v;
    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    nhops = '0; gap_cycles = '0; continuous = 1'b0;
    start = 1'b0; stop = 1'b0; gen_hop_done = 1'b0; gen_phase_tready = 1'b1;
    tick(); tick();
    v = '{default: '0};
    v.sr = 1'b1;
    chk_all("reset", v);
    reset = 1'b0;

    wr(4'd0, 24'h000100);
    wr(4'd1, 24'h000200);
    wr(4'd2, 24'h000300);

    // st sp hd ct nh gp | busy srst tv tl fd idx phase
    add(1,0,0,0,3,0,  1,1,0,0,0,0,'h000);
    add(0,0,0,0,3,0,  1,0,1,0,0,0,'h100);
    add(0,0,0,0,3,0,  1,0,1,0,0,0,'h100);
    add(0,0,1,0,3,0,  1,1,0,0,0,1,'h100);
    add(0,0,0,0,3,0,  1,0,1,0,0,1,'h200);
    add(0,0,1,0,3,0,  1,1,0,0,0,2,'h200);
    add(0,0,0,0,3,0,  1,0,1,1,0,2,'h300);
    add(0,0,0,0,3,0,  1,0,1,1,0,2,'h300);
    add(0,0,1,0,3,0,  0,1,0,0,1,0,'h300);
    add(0,0,1,0,3,0,  0,1,0,0,0,0,'h300);
    add(1,0,0,0,0,0,  0,1,0,0,0,0,'h300);
    add(1,0,0,0,17,0, 0,1,0,0,0,0,'h300);
    add(1,0,0,0,2,0,  1,1,0,0,0,0,'h300);
    add(0,0,0,0,2,0,  1,0,1,0,0,0,'h100);
    add(0,0,1,0,2,0,  1,1,0,0,0,1,'h100);
    add(1,0,0,0,3,0,  1,0,1,1,0,1,'h200);
    add(0,0,1,0,3,0,  0,1,0,0,1,0,'h200);
    add(1,0,0,1,2,0,  1,1,0,0,0,0,'h200);
    add(0,0,0,1,2,0,  1,0,1,0,0,0,'h100);
    add(0,0,1,1,2,0,  1,1,0,0,0,1,'h100);
    add(0,0,0,1,2,0,  1,0,1,1,0,1,'h200);
    add(0,0,1,1,2,0,  1,1,0,0,1,0,'h200);
    add(0,0,0,1,2,0,  1,0,1,0,0,0,'h100);
    add(0,1,0,1,2,0,  0,1,0,0,0,0,'h100);
    add(1,0,0,0,3,0,  1,1,0,0,0,0,'h100);
    add(0,0,0,0,3,0,  1,0,1,0,0,0,'h100);
    add(0,1,1,0,3,0,  0,1,0,0,0,0,'h100);
    add(0,0,0,0,3,0,  0,1,0,0,0,0,'h100);
    add(1,0,0,0,3,0,  1,1,0,0,0,0,'h100);
    add(0,0,0,0,3,0,  1,0,1,0,0,0,'h100);
    add(0,0,1,0,3,0,  1,1,0,0,0,1,'h100);
    add(0,1,0,0,3,0,  0,1,0,0,0,1,'h200);

    foreach (vq[i]) begin
      start = vq[i].st; stop = vq[i].sp; gen_hop_done = vq[i].hd;
      continuous = vq[i].ct; nhops = vq[i].nh; gap_cycles = vq[i].gp;
      tick();
      chk_all($sformatf("v%0d", i), vq[i]);
    end
    start = 1'b0; stop = 1'b0; gen_hop_done = 1'b0; continuous = 1'b0;

    // Inter-hop gap: 5 GAP cycles plus LOAD before tvalid returns.
    nhops = 5'd3; gap_cycles = 16'd5; start = 1'b1;
    wait_tv(n, idle);
    chk("gap.start_lat", n, 32'd2);
    chk("gap.ph0", {8'd0, hop_phase_inc}, 32'h100);
    for (int k = 1; k < 3; k++) begin
      gen_hop_done = 1'b1;
      wait_tv(n, idle);
      chk($sformatf("gap.lat%0d", k), n, 32'd7);
      chk($sformatf("gap.idle%0d", k), idle, 32'd6);
      chk($sformatf("gap.idx%0d", k), {28'd0, hop_idx}, k);
      chk($sformatf("gap.ph%0d", k), {8'd0, hop_phase_inc}, 32'h100 * (k + 1));
    end
    chk("gap.tlast", {31'd0, gen_phase_tlast}, 32'd1);
    gen_hop_done = 1'b1;
    tick();
    gen_hop_done = 1'b0;
    chk("gap.fd", {31'd0, frame_done}, 32'd1);
    chk("gap.busy", {31'd0, busy}, 32'd0);

    // Write to the live entry lands only at its next LOAD; reset keeps the table.
    nhops = 5'd1; gap_cycles = '0; continuous = 1'b1; start = 1'b1;
    wait_tv(n, idle);
    chk("wr.ph_before", {8'd0, hop_phase_inc}, 32'h100);
    wr(4'd0, 24'h000ABC);
    chk("wr.ph_held", {8'd0, hop_phase_inc}, 32'h100);
    gen_hop_done = 1'b1;
    wait_tv(n, idle);
    chk("wr.lat", n, 32'd2);
    chk("wr.ph_after", {8'd0, hop_phase_inc}, 32'hABC);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    v = '{default: '0};
    v.sr = 1'b1;
    chk_all("rst_mid", v);
    continuous = 1'b0; start = 1'b1;
    wait_tv(n, idle);
    chk("rst.table_kept", {8'd0, hop_phase_inc}, 32'hABC);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("rst.stop_busy", {31'd0, busy}, 32'd0);

`ifdef MTX_HOP_SCHED_LFSR_EN
    lfsr_run(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lfsr_run(1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
